// File: rtl/path_replayer_if.sv
// path_replayer_if: bundles the run control, path-queue read port, replay
// status outputs and maze-memory read port of the path replayer.
// master = environment side (drives run/queue/mem_d), slave = replayer side.
interface path_replayer_if;
    logic       run;
    logic       q_empty;
    logic [1:0] q_data;
    logic       dequeue;
    logic [3:0] pos_x;
    logic [3:0] pos_y;
    logic       step_valid;
    logic [7:0] step_count;
    logic       busy;
    logic       done;
    logic [1:0] err_code;
    logic [3:0] mem_x;
    logic [3:0] mem_y;
    logic       mem_rd;
    logic       mem_d;

    modport master (
        output run, q_empty, q_data, mem_d,
        input  dequeue, pos_x, pos_y, step_valid, step_count,
               busy, done, err_code, mem_x, mem_y, mem_rd
    );

    modport slave (
        input  run, q_empty, q_data, mem_d,
        output dequeue, pos_x, pos_y, step_valid, step_count,
               busy, done, err_code, mem_x, mem_y, mem_rd
    );
endinterface

// File: rtl/path_replayer.sv
// path_replayer: pops the solver's path queue (last move first) and walks
// from (GOAL_X,GOAL_Y) back to the origin by applying each move's inverse.
// Every applied step is published on pos_x/pos_y with a step_valid pulse;
// the walk is checked for staying inside the 16x16 grid and for ending at
// (0,0) once the queue runs dry.
// Optional build macro REPLAY_MEMCHECK_EN: each in-bounds step is first
// checked against the maze memory (one extra MEMCHK cycle); a cell that
// reads back 0 aborts the replay with err_code 11.
module path_replayer #(
    parameter int GOAL_X      = 15,
    parameter int GOAL_Y      = 15,
    parameter int PACE_CYCLES = 0
) (
    input logic            clk,
    input logic            rst,
    path_replayer_if.slave bus
);
    // Pace counter only needs to reach PACE_CYCLES-1; keep at least 1 bit.
    localparam int         PW        = (PACE_CYCLES > 1) ? $clog2(PACE_CYCLES) : 1;
    localparam int         PACE_LAST = (PACE_CYCLES > 0) ? PACE_CYCLES - 1 : 0;
    localparam logic [3:0] GX        = 4'(GOAL_X);
    localparam logic [3:0] GY        = 4'(GOAL_Y);

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_OOB   = 2'b01;
    localparam logic [1:0] ERR_ORIG  = 2'b10;
    localparam logic [1:0] ERR_CELL  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_APPLY,
`ifdef REPLAY_MEMCHECK_EN
        S_MEMCHK,
`endif
        S_PACE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    pos_x_q, pos_x_d;
    logic [3:0]    pos_y_q, pos_y_d;
    logic [1:0]    op_q, op_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          step_vld_q, step_vld_d;
    logic [1:0]    err_q, err_d;
    logic [PW-1:0] pace_q, pace_d;

    logic [1:0]    inv_op;
    logic [4:0]    cand_x, cand_y;
    logic          cand_oob;
    logic          take_step;
    logic          deq;
    logic          busy;
    logic          mem_rd;
    logic [3:0]    mem_x, mem_y;

    // Candidate position: current position moved by the inverse of the
    // latched opcode, in 5 bits so that both 0-1 and 15+1 land on bit 4.
    always_comb begin
        inv_op = op_q ^ 2'b10;
        cand_x = {1'b0, pos_x_q};
        cand_y = {1'b0, pos_y_q};
        unique case (inv_op)
            2'b00: cand_x = {1'b0, pos_x_q} + 5'd1;
            2'b01: cand_y = {1'b0, pos_y_q} + 5'd1;
            2'b10: cand_x = {1'b0, pos_x_q} - 5'd1;
            2'b11: cand_y = {1'b0, pos_y_q} - 5'd1;
            default: ;
        endcase
        cand_oob = cand_x[4] | cand_y[4];
    end

    // State register and replay datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pos_x_q    <= '0;
            pos_y_q    <= '0;
            op_q       <= '0;
            cnt_q      <= '0;
            step_vld_q <= 1'b0;
            err_q      <= ERR_NONE;
            pace_q     <= '0;
        end else begin
            state_q    <= state_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            step_vld_q <= step_vld_d;
            err_q      <= err_d;
            pace_q     <= pace_d;
        end
    end

    // Next-state logic: sequencing, queue pop, error detection and the
    // position/step-count update when a step is accepted.
    always_comb begin
        state_d    = state_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        step_vld_d = 1'b0;
        err_d      = err_q;
        pace_d     = pace_q;
        take_step  = 1'b0;
        deq        = 1'b0;
        mem_rd     = 1'b0;
        mem_x      = '0;
        mem_y      = '0;

        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (bus.run) begin
                    pos_x_d = GX;
                    pos_y_d = GY;
                    cnt_d   = '0;
                    err_d   = ERR_NONE;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (!bus.q_empty) begin
                    deq     = 1'b1;
                    op_d    = bus.q_data;
                    state_d = S_APPLY;
                end else if (pos_x_q == 4'd0 && pos_y_q == 4'd0) begin
                    state_d = S_DONE;
                end else begin
                    err_d   = ERR_ORIG;
                    state_d = S_ERROR;
                end
            end
            S_APPLY: begin
                if (cand_oob) begin
                    err_d   = ERR_OOB;
                    state_d = S_ERROR;
                end else begin
`ifdef REPLAY_MEMCHECK_EN
                    state_d = S_MEMCHK;
`else
                    take_step = 1'b1;
`endif
                end
            end
`ifdef REPLAY_MEMCHECK_EN
            // Single-cycle combinational read of the candidate cell.
            S_MEMCHK: begin
                mem_rd = 1'b1;
                mem_x  = cand_x[3:0];
                mem_y  = cand_y[3:0];
                if (bus.mem_d) begin
                    take_step = 1'b1;
                end else begin
                    err_d   = ERR_CELL;
                    state_d = S_ERROR;
                end
            end
`endif
            S_PACE: begin
                if (pace_q == PW'(PACE_LAST)) begin
                    state_d = S_FETCH;
                end else begin
                    pace_d = pace_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (take_step) begin
            pos_x_d    = cand_x[3:0];
            pos_y_d    = cand_y[3:0];
            cnt_d      = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
            step_vld_d = 1'b1;
            pace_d     = '0;
            state_d    = (PACE_CYCLES > 0) ? S_PACE : S_FETCH;
        end
    end

    // Busy covers every state that is actively walking the path.
    always_comb begin
        busy = 1'b0;
        unique case (state_q)
            S_FETCH, S_APPLY, S_PACE: busy = 1'b1;
`ifdef REPLAY_MEMCHECK_EN
            S_MEMCHK:                 busy = 1'b1;
`endif
            default:                  busy = 1'b0;
        endcase
    end

`ifndef REPLAY_MEMCHECK_EN
    // Maze memory is not consulted in this build.
    logic mem_d_unused;
    assign mem_d_unused = bus.mem_d;
`endif

    assign bus.dequeue    = deq;
    assign bus.pos_x      = pos_x_q;
    assign bus.pos_y      = pos_y_q;
    assign bus.step_valid = step_vld_q;
    assign bus.step_count = cnt_q;
    assign bus.busy       = busy;
    assign bus.done       = (state_q == S_DONE);
    assign bus.err_code   = err_q;
    assign bus.mem_rd     = mem_rd;
    assign bus.mem_x      = mem_x;
    assign bus.mem_y      = mem_y;
endmodule
